// File: rtl/spi_pkg.sv
//------------------------------------------------------------------------------
// spi_pkg : shared SPI state encoding and word-size constants.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

   localparam int SPI_WORD_W      = 12;
   localparam int SPI_MIN_CLK_DIV = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      HOLD  = 3'd4,
      GAP   = 3'd5
   } spi_state_e;

   function automatic int spi_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_phase_timer.sv
//------------------------------------------------------------------------------
// spi_phase_timer : loadable down-counter, tc_o high once the count reaches 0.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_phase_timer
   import spi_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] val_i,
   output logic             tc_o
);

   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - C_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// spi_master : single-clock SPI master, full-duplex MSB-first word transfers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_master
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_WORD_W,
   parameter int CLK_DIV    = SPI_MIN_CLK_DIV,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  miso_i,
   output logic                  sclk_o,
   output logic                  mosi_o,
   output logic                  cs_o,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int CNT_W = $clog2(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, DATA_WIDTH) + 1);

   // Timer loads are N-1 so a state lasts exactly N cycles.
   localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] C_DIV_LD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] C_GAP_LD   = CNT_W'(CS_HOLD);
   localparam logic [CNT_W-1:0] C_BITS     = CNT_W'(DATA_WIDTH);
   localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

   spi_state_e            state_q, state_d;
   logic                  cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
   logic                  busy_q, busy_d, done_q, done_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d, tx_q, tx_d, rx_q, rx_d;
   logic [CNT_W-1:0]      bit_q, bit_d;
   logic                  tmr_load, tmr_tc;
   logic [CNT_W-1:0]      tmr_val;

   spi_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (tmr_load),
      .val_i  (tmr_val),
      .tc_o   (tmr_tc)
   );

   always_comb begin
      state_d  = state_q;
      cs_d     = cs_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dout_d   = dout_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      bit_d    = bit_q;
      tmr_load = 1'b0;
      tmr_val  = C_DIV_LD;
      case (state_q)
         IDLE: if (start_i) begin
            tx_d     = din_i;
            cs_d     = 1'b0;
            busy_d   = 1'b1;
            bit_d    = '0;
            tmr_load = 1'b1;
            tmr_val  = C_SETUP_LD;
            state_d  = SETUP;
         end
         SETUP: if (tmr_tc) begin
            sclk_d   = 1'b1;
            mosi_d   = tx_q[DATA_WIDTH-1];
            tx_d     = {tx_q[DATA_WIDTH-2:0], 1'b0};
            tmr_load = 1'b1;
            state_d  = HIGH;
         end
         HIGH: if (tmr_tc) begin
            sclk_d   = 1'b0;
            rx_d     = {rx_q[DATA_WIDTH-2:0], miso_i};
            bit_d    = bit_q + C_ONE;
            tmr_load = 1'b1;
            state_d  = LOW;
         end
         LOW: if (tmr_tc) begin
            tmr_load = 1'b1;
            if (bit_q == C_BITS) begin
               tmr_val = C_HOLD_LD;
               state_d = HOLD;
            end else begin
               sclk_d  = 1'b1;
               mosi_d  = tx_q[DATA_WIDTH-1];
               tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
               state_d = HIGH;
            end
         end
         HOLD: if (tmr_tc) begin
            cs_d     = 1'b1;
            mosi_d   = 1'b0;
            dout_d   = rx_q;
            done_d   = 1'b1;
            tmr_load = 1'b1;
            // Gap is timed from the end of the done pulse, hence one extra cycle.
            tmr_val  = C_GAP_LD;
            state_d  = GAP;
         end
         GAP: if (tmr_tc) begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dout_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         bit_q   <= bit_d;
      end
   end

   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;
   assign cs_o   = cs_q;
   assign dout_o = dout_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//------------------------------------------------------------------------------
// tb_spi_master : directed bench, behavioural slave per master, default and slow timing.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_s [2] = '{1'b0, 1'b0};
   logic [11:0] din_s   [2] = '{12'h0, 12'h0};
   logic        miso_s  [2];
   logic        sclk_w  [2], mosi_w [2], cs_w [2], busy_w [2], done_w [2];
   logic [11:0] dout_w  [2];

   logic [11:0] sdin   [2] = '{12'h0, 12'h0};
   logic [11:0] s_sh   [2], s_rx [2], s_dout [2];
   logic        sp2    [2], r1 [2], csp [2];

   int          cyc = 0;
   int          rises [2] = '{0, 0};
   int          csbad [2] = '{0, 0};
   int          dones [2] = '{0, 0};
   int          xr    [2] = '{0, 0};
   int          hirun [2] = '{0, 0};
   int          last_gap   [2] = '{0, 0};
   int          first_rise [2] = '{0, 0};
   int          last_rise  [2] = '{0, 0};
   int          half  [2] = '{0, 0};
   logic        sm    [2] = '{1'b0, 1'b0};
   logic        csm   [2] = '{1'b1, 1'b1};
   logic [11:0] mword [2] = '{12'h0, 12'h0};

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_master u_dut0 (
      .clk(clk), .rst(rst), .start_i(start_s[0]), .din_i(din_s[0]), .miso_i(miso_s[0]),
      .sclk_o(sclk_w[0]), .mosi_o(mosi_w[0]), .cs_o(cs_w[0]), .dout_o(dout_w[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0])
   );

   spi_master #(.DATA_WIDTH(12), .CLK_DIV(8), .CS_SETUP(3), .CS_HOLD(2)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start_s[1]), .din_i(din_s[1]), .miso_i(miso_s[1]),
      .sclk_o(sclk_w[1]), .mosi_o(mosi_w[1]), .cs_o(cs_w[1]), .dout_o(dout_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1])
   );

   // Slave: miso moves two clocks after each sclk rise, mosi taken at each fall.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            s_sh[i] <= '0; s_rx[i] <= '0; s_dout[i] <= '0; miso_s[i] <= 1'b0;
            sp2[i] <= 1'b0; r1[i] <= 1'b0; csp[i] <= 1'b1;
         end else begin
            sp2[i] <= sclk_w[i];
            csp[i] <= cs_w[i];
            r1[i]  <= sclk_w[i] & ~sp2[i];
            if (cs_w[i]) begin
               s_sh[i]   <= sdin[i];
               miso_s[i] <= 1'b0;
            end else if (r1[i]) begin
               miso_s[i] <= s_sh[i][11];
               s_sh[i]   <= {s_sh[i][10:0], 1'b0};
            end
            if (!cs_w[i] && !sclk_w[i] && sp2[i])
               s_rx[i] <= {s_rx[i][10:0], mosi_w[i]};
            if (cs_w[i] && !csp[i])
               s_dout[i] <= s_rx[i];
         end
      end
   end

   // Pin monitor, stamped with the index of the cycle that just ended.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!cs_w[i] && csm[i]) begin
            last_gap[i] = hirun[i];
            xr[i] = 0;
         end
         hirun[i] = cs_w[i] ? hirun[i] + 1 : 0;
         if (sclk_w[i] && !sm[i]) begin
            if (xr[i] == 0) first_rise[i] = cyc;
            xr[i]++;
            rises[i]++;
            last_rise[i] = cyc;
         end
         if (!sclk_w[i] && sm[i]) begin
            mword[i] = {mword[i][10:0], mosi_w[i]};
            half[i]  = cyc - last_rise[i];
            if (cs_w[i]) csbad[i]++;
         end
         if (sclk_w[i] && cs_w[i]) csbad[i]++;
         if (done_w[i]) dones[i]++;
         sm[i]  = sclk_w[i];
         csm[i] = cs_w[i];
      end
      cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input int i, input logic [11:0] m, input logic [11:0] s,
                       output int acc, output int dn);
      int k;
      k = 0;
      while (busy_w[i] !== 1'b0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      din_s[i] = m; sdin[i] = s; start_s[i] = 1'b1;
      @(negedge clk);
      start_s[i] = 1'b0;
      acc = cyc;
      chk("accept_cs", 32'(cs_w[i]), 32'd0);
      chk("accept_busy", 32'(busy_w[i]), 32'd1);
      dn = -1;
      for (k = 0; k < 1000 && dn < 0; k++) begin
         @(negedge clk);
         if (done_w[i]) dn = cyc;
      end
      chk("done_seen", 32'(dn >= 0), 32'd1);
      @(negedge clk);
   endtask

   initial begin
      int acc, dn, r0, b0, d0, nr, k;
      int dns [3];
      logic pv, got;
      logic [11:0] wds [3];
      logic [11:0] nxt [3];
      wds = '{12'h001, 12'hFFF, 12'h555};
      nxt = '{12'hFFF, 12'h555, 12'h000};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_cs", 32'(cs_w[0]), 32'd1);
      chk("rst_sclk", 32'(sclk_w[0]), 32'd0);
      chk("rst_mosi", 32'(mosi_w[0]), 32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_done", 32'(done_w[0]), 32'd0);
      chk("rst_dout", 32'(dout_w[0]), 32'd0);

      // Loopback
      xfer(0, 12'hA5C, 12'h3F1, acc, dn);
      chk("t1_latency", 32'(dn - acc + 1), 32'd101);
      chk("t1_mdout", 32'(dout_w[0]), 32'h3F1);
      chk("t1_sdout", 32'(s_dout[0]), 32'hA5C);
      chk("t1_mosi_word", 32'(mword[0]), 32'hA5C);

      // Pin check
      r0 = rises[0]; b0 = csbad[0];
      xfer(0, 12'h801, 12'h5AA, acc, dn);
      chk("t2_mosi_word", 32'(mword[0]), 32'h801);
      chk("t2_pulses", 32'(rises[0] - r0), 32'd12);
      chk("t2_cs_low", 32'(csbad[0] - b0), 32'd0);
      chk("t2_first_rise", 32'(first_rise[0] - acc), 32'd2);
      chk("t2_half", 32'(half[0]), 32'd4);
      chk("t2_mdout", 32'(dout_w[0]), 32'h5AA);

      // start and din poked mid-transfer
      k = 0;
      while (busy_w[0] !== 1'b0 && k < 500) begin @(negedge clk); k++; end
      d0 = dones[0];
      @(negedge clk); din_s[0] = 12'h3C6; sdin[0] = 12'h0A5; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      repeat (30) @(negedge clk);
      din_s[0] = 12'hFFF; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      repeat (40) @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      dn = -1;
      for (int j = 0; j < 300 && dn < 0; j++) begin
         @(negedge clk);
         if (done_w[0]) dn = cyc;
      end
      chk("t3_done_seen", 32'(dn >= 0), 32'd1);
      chk("t3_mdout", 32'(dout_w[0]), 32'h0A5);
      @(negedge clk);
      chk("t3_sdout", 32'(s_dout[0]), 32'h3C6);
      repeat (200) @(negedge clk);
      chk("t3_one_done", 32'(dones[0] - d0), 32'd1);
      chk("t3_idle_busy", 32'(busy_w[0]), 32'd0);

      // start held high for three transfers
      @(negedge clk); din_s[0] = wds[0]; sdin[0] = 12'h7E4; start_s[0] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         got = 1'b0;
         for (int j = 0; j < 400 && !got; j++) begin
            if (!cs_w[0]) got = 1'b1;
            else @(negedge clk);
         end
         chk("t4_accept", 32'(got), 32'd1);
         din_s[0] = nxt[t];
         if (t == 2) start_s[0] = 1'b0;
         dns[t] = -1;
         for (int j = 0; j < 400 && dns[t] < 0; j++) begin
            @(negedge clk);
            if (done_w[0]) dns[t] = cyc;
         end
         chk("t4_done_seen", 32'(dns[t] >= 0), 32'd1);
         @(negedge clk);
         chk("t4_sdout", 32'(s_dout[0]), 32'(wds[t]));
         if (t > 0) chk("t4_gap_ge2", 32'(last_gap[0] >= 2), 32'd1);
      end
      chk("t4_period_a", 32'(dns[1] - dns[0]), 32'd104);
      chk("t4_period_b", 32'(dns[2] - dns[1]), 32'd104);
      chk("t4_mdout", 32'(dout_w[0]), 32'h7E4);

      // Reset at the 5th sclk rise
      k = 0;
      while (busy_w[0] !== 1'b0 && k < 500) begin @(negedge clk); k++; end
      @(negedge clk); din_s[0] = 12'h6B2; sdin[0] = 12'h111; start_s[0] = 1'b1;
      @(negedge clk); start_s[0] = 1'b0;
      nr = 0; pv = 1'b0;
      for (int j = 0; j < 400 && nr < 5; j++) begin
         @(negedge clk);
         if (sclk_w[0] && !pv) nr++;
         pv = sclk_w[0];
      end
      chk("t5_reach_rise5", 32'(nr), 32'd5);
      d0 = dones[0];
      rst = 1'b1;
      #1;
      chk("t5_cs", 32'(cs_w[0]), 32'd1);
      chk("t5_sclk", 32'(sclk_w[0]), 32'd0);
      chk("t5_busy", 32'(busy_w[0]), 32'd0);
      chk("t5_dout", 32'(dout_w[0]), 32'd0);
      chk("t5_done", 32'(done_w[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (150) @(negedge clk);
      chk("t5_no_done", 32'(dones[0] - d0), 32'd0);
      xfer(0, 12'h123, 12'h456, acc, dn);
      chk("t5_latency", 32'(dn - acc + 1), 32'd101);
      chk("t5_mdout", 32'(dout_w[0]), 32'h456);
      chk("t5_sdout", 32'(s_dout[0]), 32'h123);

      // CLK_DIV=8, CS_SETUP=3
      xfer(1, 12'h9A7, 12'h2D4, acc, dn);
      chk("t6_first_rise", 32'(first_rise[1] - acc), 32'd3);
      chk("t6_half", 32'(half[1]), 32'd8);
      chk("t6_latency", 32'(dn - acc + 1), 32'd198);
      chk("t6_mdout", 32'(dout_w[1]), 32'h2D4);
      chk("t6_sdout", 32'(s_dout[1]), 32'h9A7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
